// File: rtl/branch_control_sequencer_if.sv
// -----------------------------------------------------------------------------
// branch_control_sequencer_if
// Bundles the signals exchanged between the branch control sequencer and
// the datapath it steers.
//   master modport (sequencer side):
//     in : IR_Data[31:0]  current instruction register contents
//          CON_out        branch-condition flag from the CON flip-flop
//          mem_ready      memory read data valid this cycle
//     out: PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in,
//          MDR_out, IR_in, Gra, Rout, CON_in, Y_in, C_out   datapath strobes
//          alu_instruction_bits[4:0]                         ALU op select
//   slave modport (datapath side): the same signals, directions reversed.
// -----------------------------------------------------------------------------
interface branch_control_sequencer_if;
   logic [31:0] IR_Data;
   logic        CON_out;
   logic        mem_ready;

   logic        PC_out;
   logic        MAR_in;
   logic        IncPC;
   logic        Z_in;
   logic        Zlow_out;
   logic        PC_in;
   logic        Read;
   logic        MDR_in;
   logic        MDR_out;
   logic        IR_in;
   logic        Gra;
   logic        Rout;
   logic        CON_in;
   logic        Y_in;
   logic        C_out;
   logic [4:0]  alu_instruction_bits;

   modport master (
      input  IR_Data, CON_out, mem_ready,
      output PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in,
             MDR_out, IR_in, Gra, Rout, CON_in, Y_in, C_out,
             alu_instruction_bits
   );

   modport slave (
      output IR_Data, CON_out, mem_ready,
      input  PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in,
             MDR_out, IR_in, Gra, Rout, CON_in, Y_in, C_out,
             alu_instruction_bits
   );
endinterface

// File: rtl/branch_control_sequencer.sv
// -----------------------------------------------------------------------------
// branch_control_sequencer
// Moore control sequencer for instruction fetch plus the br / nop / halt
// instructions of a simple bus-based datapath.
//   Fetch   : T0 -> T1 (-> T1W while memory is not ready) -> T2 -> T3
//   Branch  : T3 -> BR4 -> BR5 -> BR6 -> boundary
//   Nop     : T3 -> boundary
//   Halt    : T3 -> HALT (left only through clr); unknown opcodes also set
//             the sticky illegal flag.
//   Boundary: T0 when run=1, otherwise IDLE.
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   synchronous active-high reset, wins over everything
//   run      in   start/continue, sampled only at instruction boundaries
//   bus      if   datapath handshake and control strobes (master modport)
//   running  out  high in any fetch/execute state
//   halted   out  high in HALT
//   illegal  out  sticky, an unsupported opcode was dispatched
// Control strobes are registered images of the state. The exceptions are the
// T3 branch strobes (Gra/Rout/CON_in), qualified by the opcode that the IR
// holds while the FSM sits in T3, and PC_in in BR6, which follows CON_out.
// -----------------------------------------------------------------------------
module branch_control_sequencer (
   input  logic                              clk,
   input  logic                              clr,
   input  logic                              run,
   branch_control_sequencer_if.master        bus,
   output logic                              running,
   output logic                              halted,
   output logic                              illegal
);

   localparam logic [4:0] OP_BR    = 5'b10010;
   localparam logic [4:0] OP_NOP   = 5'b11010;
   localparam logic [4:0] OP_HALT  = 5'b11011;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_NONE = 5'b00000;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T1W  = 4'd3,
      S_T2   = 4'd4,
      S_T3   = 4'd5,
      S_BR4  = 4'd6,
      S_BR5  = 4'd7,
      S_BR6  = 4'd8,
      S_HALT = 4'd9
   } state_t;

   // Registered control word; one field per strobe driven from state only.
   typedef struct packed {
      logic       pc_out;
      logic       mar_in;
      logic       inc_pc;
      logic       z_in;
      logic       zlow_out;
      logic       pc_in;
      logic       read;
      logic       mdr_in;
      logic       mdr_out;
      logic       ir_in;
      logic       y_in;
      logic       c_out;
      logic [4:0] alu;
      logic       running;
      logic       halted;
   } ctrl_t;

   state_t     state_q;
   state_t     state_d;
   ctrl_t      ctrl_q;
   ctrl_t      ctrl_d;
   logic       illegal_q;
   logic       illegal_d;
   logic [4:0] opcode_s;
   logic       t3_br_s;
   logic       br6_s;
   logic       unused_ir_s;

   // Control word a state presents; every strobe not listed stays low.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c     = '0;
      c.alu = ALU_NONE;
      case (s)
         S_IDLE: begin
            c = '0;
         end
         S_T0: begin
            c.pc_out  = 1'b1;
            c.mar_in  = 1'b1;
            c.inc_pc  = 1'b1;
            c.z_in    = 1'b1;
            c.running = 1'b1;
         end
         S_T1: begin
            c.zlow_out = 1'b1;
            c.pc_in    = 1'b1;
            c.read     = 1'b1;
            c.mdr_in   = 1'b1;
            c.running  = 1'b1;
         end
         S_T1W: begin
            // Waiting on memory: keep the read going but never reload PC.
            c.read    = 1'b1;
            c.mdr_in  = 1'b1;
            c.running = 1'b1;
         end
         S_T2: begin
            c.mdr_out = 1'b1;
            c.ir_in   = 1'b1;
            c.running = 1'b1;
         end
         S_T3: begin
            c.running = 1'b1;
         end
         S_BR4: begin
            c.pc_out  = 1'b1;
            c.y_in    = 1'b1;
            c.running = 1'b1;
         end
         S_BR5: begin
            c.c_out   = 1'b1;
            c.z_in    = 1'b1;
            c.alu     = ALU_ADD;
            c.running = 1'b1;
         end
         S_BR6: begin
            // PC_in here is conditional and added outside the register.
            c.zlow_out = 1'b1;
            c.running  = 1'b1;
         end
         S_HALT: begin
            c.halted = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

   assign opcode_s    = bus.IR_Data[31:27];
   // Only the opcode field steers this block; the rest of IR is for others.
   assign unused_ir_s = ^bus.IR_Data[26:0];

   // Next-state and sticky illegal-flag computation.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_T0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_T0: begin
            state_d = S_T1;
         end
         S_T1, S_T1W: begin
            if (bus.mem_ready) begin
               state_d = S_T2;
            end else begin
               state_d = S_T1W;
            end
         end
         S_T2: begin
            state_d = S_T3;
         end
         S_T3: begin
            case (opcode_s)
               OP_BR: begin
                  state_d = S_BR4;
               end
               OP_NOP: begin
                  if (run) begin
                     state_d = S_T0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
               OP_HALT: begin
                  state_d = S_HALT;
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_BR4: begin
            state_d = S_BR5;
         end
         S_BR5: begin
            state_d = S_BR6;
         end
         S_BR6: begin
            if (run) begin
               state_d = S_T0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control word for the state being entered, so outputs leave a flop.
   always_comb begin
      ctrl_d = decode_ctrl(state_d);
   end

   // State, control and illegal registers; clr overrides every other input.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // T3 strobes depend on the instruction just loaded into IR in T2, which
   // is only visible once T3 has been entered.
   assign t3_br_s = (state_q == S_T3) && (opcode_s == OP_BR);
   assign br6_s   = (state_q == S_BR6);

   assign bus.PC_out               = ctrl_q.pc_out;
   assign bus.MAR_in               = ctrl_q.mar_in;
   assign bus.IncPC                = ctrl_q.inc_pc;
   assign bus.Z_in                 = ctrl_q.z_in;
   assign bus.Zlow_out             = ctrl_q.zlow_out;
   assign bus.PC_in                = ctrl_q.pc_in | (br6_s & bus.CON_out);
   assign bus.Read                 = ctrl_q.read;
   assign bus.MDR_in               = ctrl_q.mdr_in;
   assign bus.MDR_out              = ctrl_q.mdr_out;
   assign bus.IR_in                = ctrl_q.ir_in;
   assign bus.Gra                  = t3_br_s;
   assign bus.Rout                 = t3_br_s;
   assign bus.CON_in               = t3_br_s;
   assign bus.Y_in                 = ctrl_q.y_in;
   assign bus.C_out                = ctrl_q.c_out;
   assign bus.alu_instruction_bits = ctrl_q.alu;

   assign running = ctrl_q.running;
   assign halted  = ctrl_q.halted;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_branch_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_control_sequencer
// Directed stimulus pushes the hand-computed observable word expected after
// each clock edge into a queue; an independent monitor pops one entry per
// falling edge and compares it with the DUT outputs.
// Observable word (23 bits, MSB first):
//   running halted illegal PC_out MAR_in IncPC Z_in Zlow_out PC_in Read
//   MDR_in MDR_out IR_in Gra Rout CON_in Y_in C_out alu[4:0]
// -----------------------------------------------------------------------------
module tb_branch_control_sequencer;

   logic clk;
   logic clr;
   logic run;
   logic running;
   logic halted;
   logic illegal;

   branch_control_sequencer_if bus ();

   branch_control_sequencer dut (
      .clk     (clk),
      .clr     (clr),
      .run     (run),
      .bus     (bus.master),
      .running (running),
      .halted  (halted),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [22:0] B_RUN  = 23'd1 << 22;
   localparam logic [22:0] B_HLT  = 23'd1 << 21;
   localparam logic [22:0] B_ILL  = 23'd1 << 20;
   localparam logic [22:0] B_PCO  = 23'd1 << 19;
   localparam logic [22:0] B_MAR  = 23'd1 << 18;
   localparam logic [22:0] B_INC  = 23'd1 << 17;
   localparam logic [22:0] B_ZIN  = 23'd1 << 16;
   localparam logic [22:0] B_ZLO  = 23'd1 << 15;
   localparam logic [22:0] B_PCI  = 23'd1 << 14;
   localparam logic [22:0] B_RD   = 23'd1 << 13;
   localparam logic [22:0] B_MDRI = 23'd1 << 12;
   localparam logic [22:0] B_MDRO = 23'd1 << 11;
   localparam logic [22:0] B_IRI  = 23'd1 << 10;
   localparam logic [22:0] B_GRA  = 23'd1 << 9;
   localparam logic [22:0] B_ROUT = 23'd1 << 8;
   localparam logic [22:0] B_CONI = 23'd1 << 7;
   localparam logic [22:0] B_YIN  = 23'd1 << 6;
   localparam logic [22:0] B_COUT = 23'd1 << 5;

   localparam logic [22:0] E_IDLE  = 23'd0;
   localparam logic [22:0] E_T0    = B_RUN | B_PCO | B_MAR | B_INC | B_ZIN;
   localparam logic [22:0] E_T1    = B_RUN | B_ZLO | B_PCI | B_RD | B_MDRI;
   localparam logic [22:0] E_T1W   = B_RUN | B_RD | B_MDRI;
   localparam logic [22:0] E_T2    = B_RUN | B_MDRO | B_IRI;
   localparam logic [22:0] E_T3    = B_RUN;
   localparam logic [22:0] E_T3BR  = B_RUN | B_GRA | B_ROUT | B_CONI;
   localparam logic [22:0] E_BR4   = B_RUN | B_PCO | B_YIN;
   localparam logic [22:0] E_BR5   = B_RUN | B_COUT | B_ZIN | 23'd3;
   localparam logic [22:0] E_BR6_0 = B_RUN | B_ZLO;
   localparam logic [22:0] E_BR6_1 = B_RUN | B_ZLO | B_PCI;
   localparam logic [22:0] E_HALT  = B_HLT;
   localparam logic [22:0] E_ILL   = B_HLT | B_ILL;

   logic [22:0] obs_s;
   assign obs_s = {running, halted, illegal,
                   bus.PC_out, bus.MAR_in, bus.IncPC, bus.Z_in, bus.Zlow_out,
                   bus.PC_in, bus.Read, bus.MDR_in, bus.MDR_out, bus.IR_in,
                   bus.Gra, bus.Rout, bus.CON_in, bus.Y_in, bus.C_out,
                   bus.alu_instruction_bits};

   logic [22:0] exp_q[$];
   string       name_q[$];
   int          n_cmp;
   int          n_bad;

   initial begin
      n_cmp = 0;
      n_bad = 0;
   end

   // Monitor: one expected word per falling edge while the queue holds one.
   always @(negedge clk) begin
      logic [22:0] e;
      string       nm;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_cmp = n_cmp + 1;
         if (obs_s !== e) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", nm, obs_s, e);
         end
      end
   end

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [1:0] c2);
      logic [31:0] ir;
      ir        = 32'h0000_0000;
      ir[31:27] = op;
      ir[20:19] = c2;
      return ir;
   endfunction

   // Drive one cycle of inputs and queue the word expected after the edge.
   task automatic step(input logic r, input logic m, input logic c, input logic cl,
                       input logic [22:0] e, input string nm);
      run           = r;
      bus.mem_ready = m;
      bus.CON_out   = c;
      clr           = cl;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      run         = 1'b0;
      clr         = 1'b1;
      bus.mem_ready = 1'b0;
      bus.CON_out = 1'b0;
      bus.IR_Data = 32'h0000_0000;

      // Reset state
      step(1'b1, 1'b1, 1'b0, 1'b1, E_IDLE, "reset");
      step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "idle_hold");

      // Branch, CON_out=0: seven cycles T0..BR6, PC_in stays low in BR6
      bus.IR_Data = mk_ir(5'b10010, 2'b10);
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T0,    "br0_T0");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T1,    "br0_T1");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T2,    "br0_T2");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T3BR,  "br0_T3");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_BR4,   "br0_BR4");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_BR5,   "br0_BR5");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_BR6_0, "br0_BR6");
      step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE,  "br0_end");

      // Branch, CON_out=1, run dropped in BR4/BR5: BR6 completes then IDLE
      step(1'b1, 1'b1, 1'b1, 1'b0, E_T0,    "br1_T0");
      step(1'b1, 1'b1, 1'b1, 1'b0, E_T1,    "br1_T1");
      step(1'b1, 1'b1, 1'b1, 1'b0, E_T2,    "br1_T2");
      step(1'b1, 1'b1, 1'b1, 1'b0, E_T3BR,  "br1_T3");
      step(1'b1, 1'b1, 1'b1, 1'b0, E_BR4,   "br1_BR4");
      step(1'b0, 1'b1, 1'b1, 1'b0, E_BR5,   "br1_BR5");
      step(1'b0, 1'b1, 1'b1, 1'b0, E_BR6_1, "br1_BR6");
      step(1'b0, 1'b1, 1'b1, 1'b0, E_IDLE,  "br1_end");

      // Nop with three memory wait cycles; mem_ready elsewhere is ignored
      bus.IR_Data = mk_ir(5'b11010, 2'b00);
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T0,    "wt_T0");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1,    "wt_T1");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1W,   "wt_T1W_a");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1W,   "wt_T1W_b");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1W,   "wt_T1W_c");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T2,    "wt_T2");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T3,    "wt_T3");
      step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE,  "wt_end");

      // Back-to-back nops: four-cycle loop
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, E_T0, $sformatf("nop%0d_T0", i));
         step(1'b1, 1'b1, 1'b0, 1'b0, E_T1, $sformatf("nop%0d_T1", i));
         step(1'b1, 1'b1, 1'b0, 1'b0, E_T2, $sformatf("nop%0d_T2", i));
         step(1'b1, 1'b1, 1'b0, 1'b0, E_T3, $sformatf("nop%0d_T3", i));
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "nop_end");

      // Illegal opcode: HALT with illegal, stuck for 10 cycles, clr recovers
      bus.IR_Data = mk_ir(5'b00000, 2'b00);
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T0, "ill_T0");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T1, "ill_T1");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T2, "ill_T2");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T3, "ill_T3");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_ILL, "ill_halt");
      for (int i = 0; i < 10; i++) begin
         step(1'(i % 2), 1'((i / 2) % 2), 1'b1, 1'b0, E_ILL,
              $sformatf("ill_hold%0d", i));
      end
      step(1'b1, 1'b1, 1'b0, 1'b1, E_IDLE, "ill_clr");
      step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "ill_after");

      // Halt opcode: halted without illegal
      bus.IR_Data = mk_ir(5'b11011, 2'b00);
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T0,   "hlt_T0");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T1,   "hlt_T1");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T2,   "hlt_T2");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_T3,   "hlt_T3");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_HALT, "hlt_halt");
      step(1'b1, 1'b1, 1'b0, 1'b0, E_HALT, "hlt_hold");
      step(1'b1, 1'b1, 1'b0, 1'b1, E_IDLE, "hlt_clr");

      // clr during T1W beats run and mem_ready
      bus.IR_Data = mk_ir(5'b11010, 2'b00);
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T0,   "cw_T0");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1,   "cw_T1");
      step(1'b1, 1'b0, 1'b0, 1'b0, E_T1W,  "cw_T1W");
      step(1'b1, 1'b1, 1'b0, 1'b1, E_IDLE, "cw_clr");
      step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "cw_idle");

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_control_sequencer.md
BRANCH_CONTROL_SEQUENCER -- requirements
Module: branch_control_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-high.
- run  in  1  start/continue; sampled at instruction boundaries.
- IR_Data  in  32  current instruction; opcode IR[31:27], C2 condition IR[20:19].
- CON_out  in  1  branch-condition flag from CON FF.
- mem_ready  in  1  memory read data valid this cycle.
- PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out, IR_in, Gra, Rout, CON_in, Y_in, C_out  out  1 each  datapath controls.
- alu_instruction_bits  out  5  ALU operation select.
- running  out  1  high in any fetch/execute state.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; unsupported opcode seen.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Opcodes SHALL be fixed: br = 5'b10010, nop = 5'b11010, halt = 5'b11011; ALU ADD = 5'b00011.

Function
REQ-004 The block SHALL be a Moore FSM; every control output SHALL be decoded from present state only, except PC_in in BR6.
REQ-005 The states SHALL be IDLE, T0, T1, T1W, T2, T3, BR4, BR5, BR6, HALT.
REQ-006 IDLE: all controls 0; go to T0 when run=1, else stay.
REQ-007 T0: PC_out, MAR_in, IncPC, Z_in = 1; next state T1.
REQ-008 T1: Zlow_out, PC_in, Read, MDR_in = 1; next T2 if mem_ready=1, else T1W.
REQ-009 T1W: Read, MDR_in = 1 only; stay while mem_ready=0; go to T2 on mem_ready=1. PC_in SHALL NOT be asserted in T1W.
REQ-010 T2: MDR_out, IR_in = 1; next T3.
REQ-011 T3 SHALL dispatch on IR_Data[31:27] as registered at the T3 edge:
- br: Gra, Rout, CON_in = 1; next BR4.
- nop: no controls; next boundary.
- halt: no controls; next HALT.
- other: no controls; set illegal; next HALT.
REQ-012 BR4: PC_out, Y_in = 1; next BR5.
REQ-013 BR5: C_out, Z_in = 1 and alu_instruction_bits = 5'b00011; next BR6.
REQ-014 BR6: Zlow_out = 1 and PC_in = CON_out; next boundary.
REQ-015 Boundary: next state is T0 if run=1, else IDLE.
REQ-016 Branch latency: T0 to BR6 inclusive SHALL take 7 cycles plus one per T1W cycle. Nop SHALL take 4 cycles plus T1W cycles.
REQ-017 alu_instruction_bits SHALL be 5'b00000 in every state except BR5.
REQ-018 HALT: all datapath controls 0, halted = 1; exit only via clr.
REQ-019 Deasserting run mid-instruction SHALL NOT abort the instruction; the block stops at the next boundary.
REQ-020 mem_ready outside T1/T1W SHALL be ignored.
REQ-021 running SHALL be 1 in T0..BR6 and 0 in IDLE/HALT.
REQ-022 No two of PC_in/IR_in/Y_in/Z_in/MAR_in/MDR_in conflicts arise: at most one bus driver (PC_out, Zlow_out, MDR_out, Rout, C_out) SHALL be asserted per cycle.

Reset
REQ-023 When clr=1 at a rising edge, the state SHALL become IDLE, all outputs 0, and illegal cleared, regardless of current state including T1W and HALT.
REQ-024 clr SHALL take priority over run and mem_ready in the same cycle.

Verification
REQ-025 The bench SHALL cover these scenarios:
- clr, then run=1, mem_ready=1, IR=br (C2=10), CON_out=0 -> states T0,T1,T2,T3,BR4,BR5,BR6 in 7 cycles; PC_in=0 in BR6; alu_instruction_bits=00011 only in BR5.
- Same with CON_out=1 -> PC_in=1 and Zlow_out=1 in BR6.
- mem_ready=0 for 3 cycles after T1 -> three T1W cycles with Read=1 and PC_in=0; T2 follows the mem_ready=1 cycle.
- IR opcode 5'b00000 -> illegal=1, halted=1, running=0; hold 10 cycles, no change; clr -> IDLE, illegal=0.
- run dropped during BR5 -> BR6 completes, then IDLE; nop back-to-back with run=1 -> 4-cycle loop.
- clr asserted during T1W -> IDLE next edge, Read=0, MDR_in=0.
